hex_digit_scanner: RTL and testbench

//   Upstream stage of the 4-bit -> 7-segment decoder for boards with shared segment lines.
//   - Holds a DIGITS-nibble display value written by the CPU I/O path.
//   - Time-multiplexes the value, one nibble per scan slot, onto a single num[3:0] bus

---
 rtl/hex_digit_scanner.sv | 132 +++++++++++++
 tb/tb_hex_digit_scanner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner
//   Scan stage in front of a single shared 4-bit -> 7-segment decoder.
//   Holds a DIGITS-nibble display value and a per-digit blank mask,
//   time-multiplexes one nibble per scan slot onto num, and drives an
//   active-low one-hot digit select plus a blank flag. CPU writes land in a
//   shadow buffer and are committed only when the scan wraps back to digit 0,
//   so a displayed frame never mixes old and new values.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   : digits above 0 whose nibble and all higher nibbles are zero
//                 are blanked in addition to the blank mask.
//     undefined : blank comes from the mask only.
//
// Ports
//   clk       in   1         clock, all state on the rising edge
//   reset     in   1         synchronous active-high reset
//   wr_valid  in   1         write request
//   wr_ready  out  1         high while no write is pending
//   wr_data   in   4*DIGITS  nibble i = value for digit i
//   wr_blank  in   DIGITS    bit i forces digit i blank
//   num       out  4         nibble for the decoder (registered)
//   digit_en  out  DIGITS    active-low one-hot digit select (registered)
//   blank     out  1         current digit dark (registered)
module hex_digit_scanner #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [4*DIGITS-1:0] wr_data,
  input  logic [DIGITS-1:0]   wr_blank,
  output logic [3:0]          num,
  output logic [DIGITS-1:0]   digit_en,
  output logic                blank
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    presc_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [4*DIGITS-1:0] shadow_value_reg;
  logic [DIGITS-1:0]   shadow_mask_reg;
  logic [4*DIGITS-1:0] active_value_reg;
  logic [DIGITS-1:0]   active_mask_reg;
  logic                pending_reg;
  logic [3:0]          num_reg;
  logic [DIGITS-1:0]   digit_en_reg;
  logic                blank_reg;

  logic                tick;
  logic [IDX_W-1:0]    idx_next;
  logic                commit;
  logic [4*DIGITS-1:0] show_value;
  logic [DIGITS-1:0]   show_mask;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   lz;
  logic                blank_next;

  assign tick     = (presc_reg == PRE_LAST);
  assign idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
  // A commit happens on the tick that brings the scan back to digit 0.
  assign commit   = tick && (idx_next == '0) && pending_reg;

  // Digit 0 on a commit edge must already show the freshly committed value.
  assign show_value = commit ? shadow_value_reg : active_value_reg;
  assign show_mask  = commit ? shadow_mask_reg  : active_mask_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]    = show_value[4*gi +: 4];
      assign onehot[gi] = (idx_next == IDX_W'(gi));
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lz0
        assign lz[gi] = 1'b0;
      end else begin : g_lzn
        assign lz[gi] = ~|show_value[4*DIGITS-1:4*gi];
      end
`else
      assign lz[gi] = 1'b0;
`endif
    end
  endgenerate

  assign blank_next = show_mask[idx_next] | lz[idx_next];

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg        <= '0;
      idx_reg          <= '0;
      shadow_value_reg <= '0;
      shadow_mask_reg  <= '0;
      active_value_reg <= '0;
      active_mask_reg  <= '0;
      pending_reg      <= 1'b0;
      num_reg          <= 4'h0;
      digit_en_reg     <= '1;
      blank_reg        <= 1'b1;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick) begin
        idx_reg      <= idx_next;
        num_reg      <= nib[idx_next];
        digit_en_reg <= ~onehot;
        blank_reg    <= blank_next;
      end
      // Accept requires pending=0 and commit requires pending=1,
      // so the two branches are mutually exclusive.
      if (commit) begin
        active_value_reg <= shadow_value_reg;
        active_mask_reg  <= shadow_mask_reg;
        pending_reg      <= 1'b0;
      end else if (wr_valid && !pending_reg) begin
        shadow_value_reg <= wr_data;
        shadow_mask_reg  <= wr_blank;
        pending_reg      <= 1'b1;
      end
    end
  end

  assign wr_ready = ~pending_reg;
  assign num      = num_reg;
  assign digit_en = digit_en_reg;
  assign blank    = blank_reg;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb_hex_digit_scanner
//   Scoreboard bench for hex_digit_scanner with DIGITS=4, PRESCALE=4.
//   The driver keeps a frame-level model (clock count since reset, pending
//   write, shadow/active value) and pushes the expected display for every
//   scan slot; a monitor pops and compares whenever digit_en changes.
module tb_hex_digit_scanner;
  localparam int D = 4;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [4*D-1:0] wr_data = '0;
  logic [D-1:0]  wr_blank = '0;
  logic [3:0]    num;
  logic [D-1:0]  digit_en;
  logic          blank;

  hex_digit_scanner #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_blank(wr_blank), .num(num),
    .digit_en(digit_en), .blank(blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   num;
    logic [D-1:0] en;
    logic         blank;
    int           digit;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // model state
  int             m_n = 0;
  bit             m_pending = 0;
  bit             m_accepted;
  logic [4*D-1:0] m_shadow_v = '0, m_active_v = '0;
  logic [D-1:0]   m_shadow_m = '0, m_active_m = '0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t expect_slot(input int d);
    exp_t e;
    logic [4*D-1:0] v;
    bit lzb;
    v = m_active_v >> (4*d);
    e.num   = v[3:0];
    e.en    = ~(D'(1) << d);
    lzb = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lzb = (d > 0) && (v == 0);
`endif
    e.blank = m_active_m[d] | lzb;
    e.digit = d;
    return e;
  endfunction

  // One clock: model the edge with the inputs the DUT sees, then check wr_ready.
  task automatic cycle();
    int d;
    @(posedge clk);
    m_accepted = 0;
    if (reset) begin
      m_n = 0; m_pending = 0;
      m_shadow_v = '0; m_shadow_m = '0; m_active_v = '0; m_active_m = '0;
    end else begin
      bit acc;
      m_n++;
      acc = wr_valid && !m_pending;
      if (m_n % P == 0) begin
        d = (m_n / P) % D;
        if (d == 0 && m_pending) begin
          m_active_v = m_shadow_v; m_active_m = m_shadow_m; m_pending = 0;
        end
        exp_q.push_back(expect_slot(d));
      end
      if (acc) begin
        m_shadow_v = wr_data; m_shadow_m = wr_blank; m_pending = 1; m_accepted = 1;
      end
    end
    @(negedge clk);
    check("wr_ready", int'(wr_ready), int'(!m_pending));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle();
      check("reset_num", int'(num), 0);
      check("reset_digit_en", int'(digit_en), 'hF);
      check("reset_blank", int'(blank), 1);
    end
    reset = 1'b0;
  endtask

  // Present a write and hold it until accepted (bounded by three frames).
  task automatic do_write(input logic [4*D-1:0] data, input logic [D-1:0] mask);
    int k;
    wr_valid = 1'b1; wr_data = data; wr_blank = mask;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!m_accepted && k < 3*D*P);
    if (!m_accepted) begin
      errors++; checks++;
      $display("FAIL write_timeout: data %0h not accepted after %0d cycles", data, k);
    end
    wr_valid = 1'b0;
  endtask

  // Monitor: each digit_en change consumes one expected slot.
  initial begin : monitor
    logic [D-1:0] last_en;
    logic rs;
    exp_t e;
    last_en = '1;
    forever begin
      @(posedge clk);
      rs = reset;
      @(negedge clk);
      if (rs) begin
        last_en = digit_en;
      end else if (digit_en !== last_en) begin
        last_en = digit_en;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_slot: digit_en=%b with no slot expected (t=%0t)", digit_en, $time);
        end else begin
          e = exp_q.pop_front();
          $display("slot digit %0d: num=%h digit_en=%b blank=%b", e.digit, num, digit_en, blank);
          check("slot_digit_en", int'(digit_en), int'(e.en));
          check("slot_num", int'(num), int'(e.num));
          check("slot_blank", int'(blank), int'(e.blank));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_slot: digit_en stayed %b, expected %b (t=%0t)", digit_en, e.en, $time);
      end
    end
  end

  initial begin
    logic [4*D-1:0] rd;
    logic [D-1:0]   rm;
    do_reset(2);
    run(20);                       // idle scan of zeros
    do_write(16'hA5C3, 4'b0000);
    run(2 * D * P);
    do_write(16'h1234, 4'b0000);   // back-to-back: second is held while pending
    do_write(16'h1111, 4'b0000);
    run(2 * D * P);
    do_write(16'h00F0, 4'b0100);
    run(2 * D * P);
    do_write(16'hBEEF, 4'b1010);   // reset lands while this is pending
    run(3);
    do_reset(1);
    run(2 * D * P);
    do_write(16'h0070, 4'b0000);
    run(2 * D * P);
    for (int i = 0; i < 25; i++) begin
      rd = 16'($urandom);
      rm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd = rd & 16'h00FF;
      do_write(rd, rm);
      run($urandom_range(0, 20));
    end
    run(2 * D * P);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
